// File: rtl/booth_acc_pkg.sv
// Shared types and defaults for the Booth product accumulator.
package booth_acc_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam int DEF_PROD_W  = 8;
  localparam int DEF_ACC_W   = 10;
  localparam int DEF_N_TERMS = 4;

  // Counter width able to hold 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/booth_acc_add_unit.sv
// Combinational accumulate step: acc + zext(product) with carry out of the
// accumulator MSB. Optional macro ACC_SATURATE_EN clamps the sum to all-ones
// on carry; otherwise the sum wraps modulo 2^ACC_W.
module booth_acc_add_unit #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 10
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  // One extra bit above the wider operand catches every carry.
  localparam int SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

  logic [SUM_W-1:0] full_sum;

  assign full_sum = SUM_W'(acc_i) + SUM_W'(prod_i);
  assign carry_o  = |full_sum[SUM_W-1:ACC_W];

`ifdef ACC_SATURATE_EN
  // Once clamped, further nonzero products carry again and keep the clamp.
  assign sum_o = carry_o ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
  assign sum_o = full_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/booth_product_accumulator.sv
// Sums N_TERMS unsigned products into one ACC_W-bit result with a sticky
// overflow flag, presented on a valid/ready output. Two states: ACCUM takes
// products, HOLD presents the result. Build option: ACC_SATURATE_EN.
module booth_product_accumulator
  import booth_acc_pkg::*;
#(
  parameter int PROD_W  = DEF_PROD_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int N_TERMS = DEF_N_TERMS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int CNT_W = cnt_width(N_TERMS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [ACC_W-1:0]  out_sum_q, out_sum_d;
  logic              out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0]  add_sum;
  logic              add_carry;

  booth_acc_add_unit #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc_i   (acc_q),
    .prod_i  (in_product),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

  // Next-state: clr beats transfers; the last product of a batch goes straight
  // to the output register and the running accumulator restarts from zero.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_sum_d = out_sum_q;
    out_ovf_d = out_ovf_q;
    if (clr) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (state_q == ST_ACCUM) begin
      if (in_valid) begin
        if (cnt_q == CNT_LAST) begin
          out_sum_d = add_sum;
          out_ovf_d = ovf_q | add_carry;
          state_d   = ST_HOLD;
          acc_d     = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
        end else begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_carry;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end else begin
      if (out_ready) begin
        state_d = ST_ACCUM;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_sum_q <= out_sum_d;
      out_ovf_q <= out_ovf_d;
    end
  end

endmodule
